cep_out_reader: RTL

//  Drains one frame of cepstral coefficients from the cepstrum RAM after the cepstrum controller signals frame done.

---
 rtl/cep_out_if.sv | 26 ++
 rtl/cep_out_reader.sv | 125 ++++++++++++
 2 files changed

// File: rtl/cep_out_if.sv
// Cepstrum RAM read port plus the outgoing coefficient stream of cep_out_reader.
// master = reader side, slave = RAM / downstream side.
interface cep_out_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 4,
  parameter int FRAME_W    = 8
);
  logic                  cep_rd_en;
  logic [ADDR_W-1:0]     cep_rd_addr;
  logic [DATA_WIDTH-1:0] cep_rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic [FRAME_W-1:0]    out_frame_num;

  modport master (
    output cep_rd_en, cep_rd_addr, out_valid, out_data, out_last, out_frame_num,
    input  cep_rd_data, out_ready
  );

  modport slave (
    input  cep_rd_en, cep_rd_addr, out_valid, out_data, out_last, out_frame_num,
    output cep_rd_data, out_ready
  );
endinterface

// File: rtl/cep_out_reader.sv
// Drains one frame of cepstral coefficients from the cepstrum RAM and streams them out
// tagged with frame number and last flag. Optional macro CEP_OUT_SKIP_C0_EN skips c0.
module cep_out_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CEP    = 13,
  parameter int ADDR_W     = 4,
  parameter int FRAME_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_done,
  cep_out_if.master     bus,
  output logic          busy,
  output logic          overrun
);

`ifdef CEP_OUT_SKIP_C0_EN
  localparam logic [ADDR_W-1:0] START = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] START = ADDR_W'(0);
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CEP - 1);

  typedef enum logic [1:0] {IDLE, RD, CAP, SEND} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      addr;
  logic [FRAME_W-1:0]     frame_cnt;
  logic                   pending, pending_nxt;
  logic                   overrun_nxt;
  logic                   start_frame;
  logic                   addr_inc;
  logic                   fd_used;
  logic [DATA_WIDTH-1:0]  data_p1;
  logic                   last_p1;
  logic [FRAME_W-1:0]     frame_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    addr_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_done || pending) begin
          start_frame = 1'b1;
          state_nxt   = RD;
        end
      end
      RD:   state_nxt = CAP;
      CAP:  state_nxt = SEND;
      SEND: begin
        if (bus.out_ready) begin
          if (last_p1) begin
            if (frame_done || pending) begin
              start_frame = 1'b1;
              state_nxt   = RD;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            addr_inc  = 1'b1;
            state_nxt = RD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A new frame consumes the pending event first; a coincident frame_done then re-arms pending.
    fd_used     = start_frame && !pending;
    pending_nxt = pending && !start_frame;
    overrun_nxt = 1'b0;
    if (frame_done && !fd_used) begin
      if (pending_nxt) overrun_nxt = 1'b1;
      else             pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      frame_cnt <= '0;
      pending   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      pending <= pending_nxt;
      overrun <= overrun_nxt;
      if (start_frame) begin
        addr      <= START;
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end else if (addr_inc) begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

  // Capture stage: RAM data lands one cycle after the read strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1  <= '0;
      last_p1  <= 1'b0;
      frame_p1 <= '0;
    end else begin
      if (state == CAP) begin
        data_p1 <= bus.cep_rd_data;
        last_p1 <= (addr == LAST_ADDR);
      end
      if (start_frame) frame_p1 <= frame_cnt;
    end
  end

  assign bus.cep_rd_en     = (state == RD);
  assign bus.cep_rd_addr   = (state == RD) ? addr : '0;
  assign bus.out_valid     = (state == SEND);
  assign bus.out_data      = data_p1;
  assign bus.out_last      = last_p1;
  assign bus.out_frame_num = frame_p1;
  assign busy              = (state != IDLE);

endmodule
